digest_output_buffer: RTL and testbench

// - Parametrised successor to the fixed 8x32 digest latch at the back end of the SHA-256 core.
// - Captures one full digest (NWORDS words of WIDTH bits) from the round datapath into a holding bank.
// - Presents the captured digest three ways: parallel, random-access read and a valid/ready word stream.
// - Adds back-pressure and an overrun flag; it sits between the hash core and the host/IO interface.

---
 rtl/digest_output_buffer.sv | 159 +++++++++++++++
 tb/tb_digest_output_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digest_output_buffer.sv
// digest_output_buffer
//   Holds one captured digest (NWORDS words of WIDTH bits) from the hash round
//   datapath. The digest is presented three ways: as a parallel copy, through a
//   registered random-access read port, and as an in-order valid/ready word
//   stream. Back-pressure is reported on cap_ready. A sticky overrun flag
//   records capture requests that arrive while the buffer is busy.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     cap_en, cap_data    capture request and flattened digest (word i at i*WIDTH)
//     cap_ready           buffer accepts a digest this cycle
//     par_data            parallel copy of the held digest
//     rd_addr, rd_data    random read, 1-cycle latency, 0 for rd_addr >= NWORDS
//     s_valid/s_ready     word stream handshake
//     s_data, s_last      stream word, s_last marks word NWORDS-1
//     overrun, ovr_clr    sticky overrun flag and its synchronous clear
//
//   Build option: define DIGEST_BSWAP_EN to byte-reverse every output word
//   (s_data, rd_data, par_data) for a little-endian host. The bank itself
//   always holds words in native order.

module digest_output_buffer #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 8,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cap_en,
  input  logic [NWORDS*WIDTH-1:0]  cap_data,
  output logic                     cap_ready,
  output logic [NWORDS*WIDTH-1:0]  par_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     s_valid,
  input  logic                     s_ready,
  output logic [WIDTH-1:0]         s_data,
  output logic                     s_last,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  if ((2 ** ADDR_W) < NWORDS) begin : g_chk_addr_w
    $error("digest_output_buffer: ADDR_W too small to address NWORDS words");
  end

`ifdef DIGEST_BSWAP_EN
  if ((WIDTH % 8) != 0) begin : g_chk_bswap_width
    $error("digest_output_buffer: byte swap requires WIDTH to be a multiple of 8");
  end
`endif

  function automatic logic [WIDTH-1:0] out_word(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = '0;
`ifdef DIGEST_BSWAP_EN
    for (int unsigned b = 0; b < WIDTH / 8; b++) begin
      r[8*b +: 8] = w[WIDTH-8-8*b +: 8];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bank_q [NWORDS];
  logic [WIDTH-1:0] bank_d [NWORDS];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             overrun_q, overrun_d;

  logic             hs;
  logic             cap_take;
  logic [WIDTH-1:0] s_word;

  always_comb begin
    s_valid = (state_q == ST_STREAM);

    // Counter only ever ranges over 0..NWORDS-1, so an explicit mux avoids
    // out-of-range array indexing for non power-of-two NWORDS.
    s_word = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (cnt_q == CNT_W'(i)) s_word = bank_q[i];
    end
    s_data = out_word(s_word);
    s_last = s_valid && (cnt_q == CNT_W'(NWORDS - 1));

    hs        = s_valid & s_ready;
    cap_ready = (state_q != ST_STREAM) | (hs & s_last);
    cap_take  = cap_en & cap_ready;

    par_data = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      par_data[i*WIDTH +: WIDTH] = out_word(bank_q[i]);
    end

    rd_data = rd_data_q;
    overrun = overrun_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;

    // A capture may coincide with the last-beat handshake; it wins and
    // restarts the stream at word 0 of the new digest.
    if (cap_take) begin
      for (int unsigned i = 0; i < NWORDS; i++) begin
        bank_d[i] = cap_data[i*WIDTH +: WIDTH];
      end
      cnt_d   = '0;
      state_d = ST_STREAM;
    end else if (hs) begin
      if (s_last) begin
        cnt_d   = '0;
        state_d = ST_DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Reads see the bank as it stands before this edge's capture.
    rd_data_d = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data_d = out_word(bank_q[i]);
    end

    overrun_d = overrun_q;
    if (ovr_clr)               overrun_d = 1'b0;
    if (cap_en && !cap_ready)  overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      cnt_q     <= '0;
      rd_data_q <= '0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < NWORDS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      overrun_q <= overrun_d;
      bank_q    <= bank_d;
    end
  end

endmodule

// File: tb/tb_digest_output_buffer.sv
module tb_digest_output_buffer;

  localparam int WIDTH  = 32;
  localparam int NWORDS = 8;
  localparam int ADDR_W = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    cap_en;
  logic [NWORDS*WIDTH-1:0] cap_data;
  logic                    cap_ready;
  logic [NWORDS*WIDTH-1:0] par_data;
  logic [ADDR_W-1:0]       rd_addr;
  logic [WIDTH-1:0]        rd_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [WIDTH-1:0]        s_data;
  logic                    s_last;
  logic                    overrun;
  logic                    ovr_clr;

  int checks = 0;
  int errors = 0;

  digest_output_buffer #(
    .WIDTH (WIDTH),
    .NWORDS(NWORDS),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_en   (cap_en),
    .cap_data (cap_data),
    .cap_ready(cap_ready),
    .par_data (par_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the held digest, a queue of words still to be streamed
  // (already in output byte order), the pending read result and overrun.
  logic [31:0] m_bank [NWORDS];
  logic [31:0] m_q [$];
  logic [31:0] m_rd;
  logic        m_ovr;

  function automatic logic [31:0] ow(input logic [31:0] w);
`ifdef DIGEST_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic m_cap_ready();
    return (m_q.size() == 0) || (s_ready && m_q.size() == 1);
  endfunction

  function automatic logic [NWORDS*WIDTH-1:0] m_par();
    logic [NWORDS*WIDTH-1:0] r;
    for (int i = 0; i < NWORDS; i++) r[i*WIDTH +: WIDTH] = ow(m_bank[i]);
    return r;
  endfunction

  function automatic logic [31:0] m_front();
    return (m_q.size() > 0) ? m_q[0] : 32'h0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < NWORDS; i++) m_bank[i] = '0;
    m_rd  = '0;
    m_ovr = 1'b0;
  endtask

  // Advance one clock edge; the model reacts to the inputs present before it.
  task automatic tick();
    logic        hs, cap, novr;
    logic [31:0] nrd;
    int          a;
    hs   = (m_q.size() > 0) && s_ready;
    cap  = cap_en && m_cap_ready();
    a    = int'(rd_addr);
    nrd  = (a < NWORDS) ? ow(m_bank[a]) : 32'h0;
    novr = m_ovr;
    if (ovr_clr) novr = 1'b0;
    if (cap_en && !m_cap_ready()) novr = 1'b1;
    @(posedge clk);
    m_rd  = nrd;
    m_ovr = novr;
    if (hs) void'(m_q.pop_front());
    if (cap) begin
      m_q.delete();
      for (int i = 0; i < NWORDS; i++) begin
        m_bank[i] = cap_data[i*WIDTH +: WIDTH];
        m_q.push_back(ow(m_bank[i]));
      end
    end
    #1;
  endtask

  task automatic load_digest(input bit random, input logic [31:0] base);
    for (int i = 0; i < NWORDS; i++)
      cap_data[i*WIDTH +: WIDTH] = random ? $urandom : base + 32'(i);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cap_en = 0; s_ready = 0; rd_addr = '0; ovr_clr = 0; cap_data = '0;
    model_reset();
    #2;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got %0b exp 0", s_valid); end
    checks++; if (s_last !== 1'b0) begin errors++; $display("FAIL reset_s_last got %0b exp 0", s_last); end
    checks++; if (cap_ready !== 1'b1) begin errors++; $display("FAIL reset_cap_ready got %0b exp 1", cap_ready); end
    checks++; if (par_data !== '0) begin errors++; $display("FAIL reset_par_data got %h exp 0", par_data); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b exp 0", overrun); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream_basic();
    int beats = 0;
    load_digest(0, 32'h1000_0000);
    cap_en = 1; s_ready = 1; #1;
    checks++; if (cap_ready !== 1'b1) begin errors++; $display("FAIL basic_cap_ready got %0b exp 1", cap_ready); end
    tick();
    cap_en = 0;
    for (int c = 0; c < 10; c++) begin
      checks++; if (s_valid !== (c < NWORDS)) begin errors++; $display("FAIL basic_valid c=%0d got %0b exp %0b", c, s_valid, c < NWORDS); end
      if (c < NWORDS) begin
        beats++;
        checks++; if (s_data !== ow(32'h1000_0000 + 32'(c))) begin errors++; $display("FAIL basic_data c=%0d got %h exp %h", c, s_data, ow(32'h1000_0000 + 32'(c))); end
        checks++; if (s_last !== (beats == NWORDS)) begin errors++; $display("FAIL basic_last c=%0d got %0b exp %0b", c, s_last, beats == NWORDS); end
      end
      tick();
    end
    checks++; if (par_data !== m_par()) begin errors++; $display("FAIL basic_par got %h exp %h", par_data, m_par()); end
    checks++; if (cap_ready !== 1'b1) begin errors++; $display("FAIL basic_done_cap_ready got %0b exp 1", cap_ready); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got [$];
    logic [31:0] exp_w [NWORDS];
    logic [31:0] prev;
    bit          stalled = 0;
    load_digest(1, 0);
    for (int i = 0; i < NWORDS; i++) exp_w[i] = ow(cap_data[i*WIDTH +: WIDTH]);
    cap_en = 1; s_ready = 0;
    tick();
    cap_en = 0;
    for (int c = 0; c < 60 && got.size() < NWORDS; c++) begin
      s_ready = (c % 4 == 0 || c % 4 == 3) ? 1'b1 : 1'b0;
      #1;
      if (stalled) begin
        checks++; if (s_data !== prev) begin errors++; $display("FAIL bp_hold c=%0d got %h exp %h", c, s_data, prev); end
      end
      checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d got %0b exp 1", c, s_valid); end
      if (s_ready) got.push_back(s_data);
      stalled = !s_ready;
      prev    = s_data;
      tick();
    end
    checks++; if (got.size() != NWORDS) begin errors++; $display("FAIL bp_count got %0d exp %0d", got.size(), NWORDS); end
    for (int i = 0; i < NWORDS && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL bp_order i=%0d got %h exp %h", i, got[i], exp_w[i]); end
    end
    s_ready = 0; #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %0b exp 0", s_valid); end
  endtask

  task automatic test_overrun();
    logic [31:0] old_w [NWORDS];
    load_digest(1, 0);
    for (int i = 0; i < NWORDS; i++) old_w[i] = ow(cap_data[i*WIDTH +: WIDTH]);
    cap_en = 1; s_ready = 0;
    tick();
    cap_en = 0; s_ready = 1;
    repeat (3) tick();
    s_ready = 0; cap_en = 1; load_digest(1, 0); #1;
    checks++; if (cap_ready !== 1'b0) begin errors++; $display("FAIL ovr_cap_ready got %0b exp 0", cap_ready); end
    tick();
    cap_en = 0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b exp 1", overrun); end
    checks++; if (s_data !== old_w[3]) begin errors++; $display("FAIL ovr_old_word got %h exp %h", s_data, old_w[3]); end
    ovr_clr = 1; cap_en = 1;
    tick();
    cap_en = 0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_clr_vs_set got %0b exp 1", overrun); end
    tick();
    ovr_clr = 0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b exp 0", overrun); end
    s_ready = 1;
    for (int i = 3; i < NWORDS; i++) begin
      checks++; if (s_data !== old_w[i]) begin errors++; $display("FAIL ovr_drain i=%0d got %h exp %h", i, s_data, old_w[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    load_digest(1, 0);
    cap_en = 1; s_ready = 1;
    tick();
    cap_en = 0;
    for (int c = 0; c < 20 && m_q.size() > 1; c++) tick();
    checks++; if (s_last !== 1'b1) begin errors++; $display("FAIL b2b_last got %0b exp 1", s_last); end
    load_digest(0, 32'hA5A5_0000);
    cap_en = 1; #1;
    checks++; if (cap_ready !== 1'b1) begin errors++; $display("FAIL b2b_cap_ready got %0b exp 1", cap_ready); end
    tick();
    cap_en = 0;
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b exp 1", s_valid); end
    checks++; if (s_data !== ow(32'hA5A5_0000)) begin errors++; $display("FAIL b2b_word0 got %h exp %h", s_data, ow(32'hA5A5_0000)); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %0b exp 0", overrun); end
    for (int c = 0; c < 20 && m_q.size() > 0; c++) tick();
  endtask

  task automatic test_random_read();
    load_digest(0, 32'h1000_0000);
    cap_en = 1; s_ready = 1;
    tick();
    cap_en = 0;
    repeat (NWORDS) tick();
    rd_addr = 4'd5;
    tick();
    checks++; if (rd_data !== ow(32'h1000_0005)) begin errors++; $display("FAIL rd_addr5 got %h exp %h", rd_data, ow(32'h1000_0005)); end
    rd_addr = 4'd9;
    tick();
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rd_addr9 got %h exp 0", rd_data); end
    rd_addr = 4'd2; load_digest(1, 0); cap_en = 1;
    tick();
    cap_en = 0;
    checks++; if (rd_data !== ow(32'h1000_0002)) begin errors++; $display("FAIL rd_old_word2 got %h exp %h", rd_data, ow(32'h1000_0002)); end
    tick();
    checks++; if (rd_data !== ow(cap_data[2*WIDTH +: WIDTH])) begin errors++; $display("FAIL rd_new_word2 got %h exp %h", rd_data, ow(cap_data[2*WIDTH +: WIDTH])); end
    for (int c = 0; c < 20 && m_q.size() > 0; c++) tick();
  endtask

  task automatic test_reset_midstream();
    logic [31:0] exp0;
`ifdef DIGEST_BSWAP_EN
    exp0 = 32'h0403_0201;
`else
    exp0 = 32'h0102_0304;
`endif
    load_digest(1, 0);
    cap_data[31:0] = 32'h0102_0304;
    cap_en = 1; s_ready = 0;
    tick();
    checks++; if (s_data !== exp0) begin errors++; $display("FAIL mid_word0 got %h exp %h", s_data, exp0); end
    cap_en = 0; s_ready = 1;
    repeat (2) tick();
    rst_n = 1'b0; #1;
    model_reset();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %0b exp 0", s_valid); end
    checks++; if (par_data !== '0) begin errors++; $display("FAIL mid_rst_par got %h exp 0", par_data); end
    checks++; if (cap_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_cap_ready got %0b exp 1", cap_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid got %0b exp 0", s_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cap_en  = ($urandom_range(0, 3) == 0);
      s_ready = ($urandom_range(0, 2) != 0);
      ovr_clr = ($urandom_range(0, 7) == 0);
      rd_addr = ADDR_W'($urandom_range(0, 15));
      if (cap_en) load_digest(1, 0);
      #1;
      checks++; if (s_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid c=%0d got %0b exp %0b", c, s_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        checks++; if (s_data !== m_front()) begin errors++; $display("FAIL rnd_data c=%0d got %h exp %h", c, s_data, m_front()); end
      end
      checks++; if (s_last !== (m_q.size() == 1)) begin errors++; $display("FAIL rnd_last c=%0d got %0b exp %0b", c, s_last, m_q.size() == 1); end
      checks++; if (cap_ready !== m_cap_ready()) begin errors++; $display("FAIL rnd_cap_ready c=%0d got %0b exp %0b", c, cap_ready, m_cap_ready()); end
      checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL rnd_rd c=%0d got %h exp %h", c, rd_data, m_rd); end
      checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun c=%0d got %0b exp %0b", c, overrun, m_ovr); end
      checks++; if (par_data !== m_par()) begin errors++; $display("FAIL rnd_par c=%0d got %h exp %h", c, par_data, m_par()); end
      tick();
    end
    cap_en = 0; ovr_clr = 0;
  endtask

  initial begin
    test_reset();
    test_stream_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_random_read();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
